// File: rtl/reg_index_encoder.sv
// Serialises a 32-bit register-select mask into one 5-bit register index per
// handshake, lowest- or highest-numbered first, with optional r0 suppression.
module reg_index_encoder #(
  parameter bit SKIP_R0       = 1'b1,
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic [5:0]  remaining
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [31:0] masked;
  logic [4:0]  sel_idx;
  logic        accept;
  logic        xfer;

  // Later matches overwrite earlier ones, so scan direction sets the priority.
  function automatic logic [4:0] pick_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (PRIORITY_HIGH) begin
        if (v[i]) idx = 5'(i);
      end else begin
        if (v[31-i]) idx = 5'(31 - i);
      end
    end
    return idx;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  always_comb begin
    masked = in_bits;
    if (SKIP_R0) masked[0] = 1'b0;
  end

  assign sel_idx = pick_index(pending_q);
  assign accept  = in_valid && (state_q == IDLE);
  assign xfer    = out_ready && (state_q == EMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (masked != '0)) state_d = EMIT;
      EMIT:    if (xfer && (remaining_q == 6'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An all-zero masked vector is accepted but leaves pending empty.
  always_comb begin
    pending_d   = pending_q;
    remaining_d = remaining_q;
    if (accept && (masked != '0)) begin
      pending_d   = masked;
      remaining_d = popcount(masked);
    end else if (xfer) begin
      pending_d[sel_idx] = 1'b0;
      remaining_d        = remaining_q - 6'd1;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    out_index = (state_q == EMIT) ? sel_idx : 5'd0;
    out_last  = (state_q == EMIT) && (remaining_q == 6'd1);
    remaining = remaining_q;
  end

endmodule
